// File: rtl/host_command_sequencer_if.sv
// Command/UART bundle between a host command source and the sequencer.
// No logic here; the master modport is the sequencer side, slave is the environment.
// Handshake: command_valid/command_ready; UART side is strobe + busy paced.
interface host_command_sequencer_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic                       command_valid;
   logic                       command_ready;
   logic [1:0]                 command_type;
   logic [ADDRESS_WIDTH-1:0]   command_address;
   logic [DATA_WIDTH-1:0]      command_data;
   logic [DATA_WIDTH-1:0]      command_operand_A;
   logic [DATA_WIDTH-1:0]      command_operand_B;
   logic [3:0]                 command_ALU_function;
   logic                       transmitter_parallel_data_valid;
   logic [DATA_WIDTH-1:0]      transmitter_parallel_data;
   logic                       transmitter_busy;
   logic                       receiver_parallel_data_valid;
   logic [DATA_WIDTH-1:0]      receiver_parallel_data;
   logic                       response_valid;
   logic [2*DATA_WIDTH-1:0]    response_data;
   logic                       response_timeout;

   modport master (
      input  command_valid, command_type, command_address, command_data,
             command_operand_A, command_operand_B, command_ALU_function,
             transmitter_busy, receiver_parallel_data_valid, receiver_parallel_data,
      output command_ready, transmitter_parallel_data_valid, transmitter_parallel_data,
             response_valid, response_data, response_timeout
   );

   modport slave (
      output command_valid, command_type, command_address, command_data,
             command_operand_A, command_operand_B, command_ALU_function,
             transmitter_busy, receiver_parallel_data_valid, receiver_parallel_data,
      input  command_ready, transmitter_parallel_data_valid, transmitter_parallel_data,
             response_valid, response_data, response_timeout
   );
endinterface

// File: rtl/host_command_sequencer.sv
// Turns one command descriptor into a UART byte frame and gathers the 0/1/2-byte reply.
// Latency: first TX strobe 2 cycles after acceptance; all outputs registered.
// Backpressure: one command in flight (ready only in IDLE); bytes paced by transmitter_busy.
// Optional watchdog on awaited events: define HOST_COMMAND_SEQUENCER_TIMEOUT_EN.
module host_command_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   host_command_sequencer_if.master bus
);

   localparam logic [DATA_WIDTH-1:0] SYNC_WRITE = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] SYNC_READ  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] SYNC_ALU   = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] SYNC_NOOP  = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_WAIT_RESPONSE
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;

   // captured descriptor
   logic [1:0]                r_type;
   logic [ADDRESS_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [DATA_WIDTH-1:0]     r_op_a;
   logic [DATA_WIDTH-1:0]     r_op_b;
   logic [3:0]                r_func;
   logic [1:0]                r_index;
   logic [1:0]                r_rx_count;

   // registered outputs
   logic                      r_cmd_rdy;
   logic                      r_tx_vld;
   logic [DATA_WIDTH-1:0]     r_tx_dat;
   logic                      r_rsp_vld;
   logic [2*DATA_WIDTH-1:0]   r_rsp_dat;
   logic                      r_rsp_timeout;

   logic                      w_accept;
   logic [1:0]                w_last_index;
   logic [1:0]                w_resp_len;
   logic                      w_last_byte;
   logic                      w_rx_done;
   logic [DATA_WIDTH-1:0]     w_frame_byte;
   logic                      w_timeout_hit;
   logic                      w_tx_load;
   logic                      w_index_inc;
   logic                      w_write_done;
   logic                      w_rx_store;
   logic                      w_rsp_done;

   assign w_accept    = bus.command_valid && r_cmd_rdy;
   assign w_last_byte = (r_index == w_last_index);
   assign w_rx_done   = ((r_rx_count + 2'd1) == w_resp_len);

   // frame length (as last byte index) and expected reply length per command type
   always_comb begin
      w_last_index = 2'd1;
      w_resp_len   = 2'd0;
      case (r_type)
         2'b00:   begin w_last_index = 2'd2; w_resp_len = 2'd0; end
         2'b01:   begin w_last_index = 2'd1; w_resp_len = 2'd1; end
         2'b10:   begin w_last_index = 2'd3; w_resp_len = 2'd2; end
         default: begin w_last_index = 2'd1; w_resp_len = 2'd2; end
      endcase
   end

   // select the frame byte at the current index; address/function zero-extended
   always_comb begin
      w_frame_byte = '0;
      case (r_type)
         2'b00: begin
            case (r_index)
               2'd0:    w_frame_byte = SYNC_WRITE;
               2'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
               default: w_frame_byte = r_data;
            endcase
         end
         2'b01: begin
            w_frame_byte = (r_index == 2'd0) ? SYNC_READ : DATA_WIDTH'(r_addr);
         end
         2'b10: begin
            case (r_index)
               2'd0:    w_frame_byte = SYNC_ALU;
               2'd1:    w_frame_byte = r_op_a;
               2'd2:    w_frame_byte = r_op_b;
               default: w_frame_byte = DATA_WIDTH'(r_func);
            endcase
         end
         default: begin
            w_frame_byte = (r_index == 2'd0) ? SYNC_NOOP : DATA_WIDTH'(r_func);
         end
      endcase
   end

`ifdef HOST_COMMAND_SEQUENCER_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   // an awaited event always wins over expiry in the same cycle
   assign w_timeout_hit = (r_tmo_cnt == TMO_LAST) &&
                          (((r_state == S_WAIT_ACK) && !bus.transmitter_busy) ||
                           ((r_state == S_WAIT_RESPONSE) && !bus.receiver_parallel_data_valid));

   // idle-cycle counter: restarts on every state change and every received byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmo_cnt <= '0;
      end else if ((w_next_state != r_state) || w_rx_store) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_RESPONSE)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_timeout_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_SEND;
         end
         S_SEND: begin
            if (!bus.transmitter_busy) w_next_state = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (bus.transmitter_busy) w_next_state = S_WAIT_DONE;
            else if (w_timeout_hit)   w_next_state = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (!bus.transmitter_busy) begin
               if (!w_last_byte)            w_next_state = S_SEND;
               else if (w_resp_len == 2'd0) w_next_state = S_IDLE;
               else                         w_next_state = S_WAIT_RESPONSE;
            end
         end
         S_WAIT_RESPONSE: begin
            if (bus.receiver_parallel_data_valid) begin
               if (w_rx_done) w_next_state = S_IDLE;
            end else if (w_timeout_hit) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // output/datapath control decode
   always_comb begin
      w_tx_load    = (r_state == S_SEND) && !bus.transmitter_busy;
      w_index_inc  = (r_state == S_WAIT_DONE) && !bus.transmitter_busy && !w_last_byte;
      w_write_done = (r_state == S_WAIT_DONE) && !bus.transmitter_busy && w_last_byte &&
                     (w_resp_len == 2'd0);
      w_rx_store   = (r_state == S_WAIT_RESPONSE) && bus.receiver_parallel_data_valid;
      w_rsp_done   = w_write_done || (w_rx_store && w_rx_done);
   end

   // descriptor capture and frame/reply progress counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_type     <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_func     <= '0;
         r_index    <= '0;
         r_rx_count <= '0;
      end else if (w_accept) begin
         r_type     <= bus.command_type;
         r_addr     <= bus.command_address;
         r_data     <= bus.command_data;
         r_op_a     <= bus.command_operand_A;
         r_op_b     <= bus.command_operand_B;
         r_func     <= bus.command_ALU_function;
         r_index    <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_index_inc) r_index    <= r_index + 2'd1;
         if (w_rx_store)  r_rx_count <= r_rx_count + 2'd1;
      end
   end

   // registered outputs; TX byte holds until the next load, reply word until next first byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd_rdy     <= 1'b1;
         r_tx_vld      <= 1'b0;
         r_tx_dat      <= '0;
         r_rsp_vld     <= 1'b0;
         r_rsp_dat     <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_cmd_rdy     <= (w_next_state == S_IDLE);
         r_tx_vld      <= w_tx_load;
         r_rsp_vld     <= w_rsp_done;
         r_rsp_timeout <= w_timeout_hit;
         if (w_tx_load) r_tx_dat <= w_frame_byte;
         if (w_write_done) begin
            r_rsp_dat <= '0;
         end else if (w_rx_store) begin
            if (r_rx_count == 2'd0)
               r_rsp_dat <= {{DATA_WIDTH{1'b0}}, bus.receiver_parallel_data};
            else
               r_rsp_dat[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.receiver_parallel_data;
         end
      end
   end

   assign bus.command_ready                   = r_cmd_rdy;
   assign bus.transmitter_parallel_data_valid = r_tx_vld;
   assign bus.transmitter_parallel_data       = r_tx_dat;
   assign bus.response_valid                  = r_rsp_vld;
   assign bus.response_data                   = r_rsp_dat;
   assign bus.response_timeout                = r_rsp_timeout;

endmodule
